if_fetch: RTL

Instruction fetch stage. Walks the program counter, reads each 32-bit instruction over the byte-wide synchronous memory port, and presents `pc_o`/`inst_o` with a valid strobe to the IF_ID register, which feeds the decoder. Accepts the decoder's redirect (`branch_flag_i`/`branch_target_i`) and pipeline stall. It is the producer end of the decoder's `pc_i`/`inst_i` path.

---
 rtl/if_fetch.sv | 80 ++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction fetch stage: assembles each 32-bit instruction from four byte
// reads, presents it with a valid strobe and honours stall and redirect.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a,
  output logic        mem_rd_en,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  localparam logic [2:0] S0   = 3'd0;
  localparam logic [2:0] S1   = 3'd1;
  localparam logic [2:0] S2   = 3'd2;
  localparam logic [2:0] S3   = 3'd3;
  localparam logic [2:0] S4   = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  logic [2:0]  state;
  logic [31:0] fetch_pc;
  logic [7:0]  b0, b1, b2;

  // S0..S3 encode the byte offset directly in state[1:0].
  always_comb begin
    mem_rd_en = 1'b0;
    mem_a     = fetch_pc;
    if (state <= S3) begin
      mem_rd_en = 1'b1;
      mem_a     = fetch_pc + {30'b0, state[1:0]};
    end
    if (!rst) mem_rd_en = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S0;
      fetch_pc     <= RESET_PC;
      b0           <= 8'h0;
      b1           <= 8'h0;
      b2           <= 8'h0;
      pc_o         <= 32'h0;
      inst_o       <= 32'h0;
      inst_valid_o <= 1'b0;
    end else if (branch_flag_i) begin
      // Redirect wins over everything, including a held instruction.
      fetch_pc     <= {branch_target_i[31:2], 2'b00};
      state        <= S0;
      inst_valid_o <= 1'b0;
    end else begin
      case (state)
        S0: state <= S1;
        S1: begin b0 <= mem_din; state <= S2; end
        S2: begin b1 <= mem_din; state <= S3; end
        S3: begin b2 <= mem_din; state <= S4; end
        S4: begin
          inst_o       <= {mem_din, b2, b1, b0};
          pc_o         <= fetch_pc;
          inst_valid_o <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (!stall_i) begin
            inst_valid_o <= 1'b0;
            fetch_pc     <= fetch_pc + 32'd4;
            state        <= S0;
          end
        end
        default: state <= S0;
      endcase
    end
  end

endmodule
